// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel run-time programmable clock divider with tick outputs
//
// Parameters:
//   CHANNELS  number of independent divider channels (>= 1)
//   CNT_W     ratio/counter width (>= 2); largest ratio is 2^CNT_W-1
// Ports:
//   clk        system clock, all state on its rising edge
//   reset      asynchronous active-low reset
//   en         per-channel run enable
//   sync       restarts every channel's period on the same edge
//   div_ratio  requested ratio, channel i in bits [i*CNT_W +: CNT_W]
//   clk_out    registered divided clock level, high for floor(R/2) cycles
//   tick       registered one-cycle pulse on the first cycle of each period
//   ratio_act  active ratio per channel (present only with CLK_DIV_RB_EN)
// Optional feature macro: CLK_DIV_RB_EN adds the ratio_act readback port.
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      sync,
  input  logic [CHANNELS*CNT_W-1:0] div_ratio,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
`ifdef CLK_DIV_RB_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] ratio_act
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ratio_q;
    logic [CNT_W-1:0] req;
    logic [CNT_W-1:0] req_san;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic             clk_q;
    logic             tick_q;

    assign req     = div_ratio[i*CNT_W +: CNT_W];
    // Ratios 0 and 1 cannot produce a two-phase clock, so they run as /2.
    assign req_san = (req < CNT_W'(2)) ? CNT_W'(2) : req;
    assign cnt_nxt = cnt + 1'b1;
    // sync forces a period restart even on a disabled channel.
    assign wrap    = sync | (en[i] & (cnt == ratio_q - 1'b1));

    // Reset parks cnt at ratio_q-1 so the first enabled edge is a wrap.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ratio_q <= CNT_W'(2);
        cnt     <= CNT_W'(1);
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        ratio_q <= req_san;
        clk_q   <= 1'b1;
        tick_q  <= 1'b1;
      end else if (en[i]) begin
        cnt     <= cnt_nxt;
        clk_q   <= (cnt_nxt < (ratio_q >> 1));
        tick_q  <= 1'b0;
      end else begin
        tick_q  <= 1'b0;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
`ifdef CLK_DIV_RB_EN
    assign ratio_act[i*CNT_W +: CNT_W] = ratio_q;
`endif
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi against a period-position model
module tb_clk_div_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk;
  logic            reset;
  logic [CH-1:0]   en;
  logic            sync;
  logic [CH*W-1:0] div_ratio;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
`ifdef CLK_DIV_RB_EN
  logic [CH*W-1:0] ratio_act;
`endif

  int checks = 0;
  int errors = 0;

  // Model: each channel is at position p (enabled cycles since period start)
  // of a period of length r; the level is high while p < r/2.
  int m_p    [CH] = '{default: 1};
  int m_r    [CH] = '{default: 2};
  bit m_tick [CH] = '{default: 0};

  clk_div_multi #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .div_ratio (div_ratio),
    .clk_out   (clk_out),
    .tick      (tick)
`ifdef CLK_DIV_RB_EN
    ,
    .ratio_act (ratio_act)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int san(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < CH; i++) begin
      if (!reset) begin
        m_r[i] = 2; m_p[i] = 1; m_tick[i] = 0;
      end else if (sync || (en[i] && m_p[i] == m_r[i] - 1)) begin
        m_p[i] = 0; m_r[i] = san(int'(div_ratio[i*W +: W])); m_tick[i] = 1;
      end else begin
        m_tick[i] = 0;
        if (en[i]) m_p[i]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("model_tick_ch%0d", i), 32'(tick[i]), 32'(m_tick[i]));
      chk($sformatf("model_clk_out_ch%0d", i), 32'(clk_out[i]), 32'(m_p[i] < m_r[i] / 2));
`ifdef CLK_DIV_RB_EN
      chk($sformatf("model_ratio_act_ch%0d", i), 32'(ratio_act[i*W +: W]), 32'(m_r[i]));
`endif
    end
  end

  // Counts falling edges until tick[ch] is seen; 300-cycle bound.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (tick[ch]) return;
    end
    checks++; errors++;
    $display("FAIL wait_tick_ch%0d: got no tick required tick within 300 cycles", ch);
  endtask

  task automatic measure(input int ch, input int per, input int high);
    int n, hi, dummy;
    wait_tick(ch, dummy);
    hi = int'(clk_out[ch]);
    n  = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (tick[ch]) break;
      hi += int'(clk_out[ch]);
    end
    chk($sformatf("period_ch%0d", ch), n, per);
    chk($sformatf("high_ch%0d", ch), hi, high);
  endtask

  task automatic set_ratio(input int ch, input int r);
    div_ratio[ch*W +: W] = W'(r);
  endtask

  initial begin
    int n;
    reset = 1'b0; en = '0; sync = 1'b0; div_ratio = '0;
    set_ratio(0, 2); set_ratio(1, 3); set_ratio(2, 4); set_ratio(3, 8);
    repeat (3) @(negedge clk);
    chk("reset_clk_out", clk_out, 0);
    chk("reset_tick", tick, 0);
`ifdef CLK_DIV_RB_EN
    chk("reset_ratio_act", ratio_act, 32'h02020202);
`endif
    reset = 1'b1;
    en = 4'hF;
    @(negedge clk);
    chk("first_edge_tick", tick, 4'hF);
    chk("first_edge_clk_out", clk_out, 4'hF);

    measure(0, 2, 1); measure(1, 3, 1); measure(2, 4, 2); measure(3, 8, 4);

    // Degenerate ratios run as /2.
    set_ratio(0, 0); set_ratio(1, 1);
    measure(0, 2, 1); measure(1, 2, 1);
`ifdef CLK_DIV_RB_EN
    chk("ratio0_act", ratio_act[0 +: W], 2);
    chk("ratio1_act", ratio_act[W +: W], 2);
`endif

    // Mid-period ratio change on channel 0.
    set_ratio(0, 4);
    measure(0, 4, 2);
    @(negedge clk);
    set_ratio(0, 6);
`ifdef CLK_DIV_RB_EN
    chk("ratio_act_hold", ratio_act[0 +: W], 4);
`endif
    wait_tick(0, n);
    chk("old_period_rest", n, 3);
`ifdef CLK_DIV_RB_EN
    chk("ratio_act_new", ratio_act[0 +: W], 6);
`endif
    measure(0, 6, 3);

    // Disable channel 1 for three cycles at cnt=2.
    set_ratio(1, 5);
    measure(1, 5, 2);
    repeat (2) @(negedge clk);
    en[1] = 1'b0;
    repeat (3) @(negedge clk);
    en[1] = 1'b1;
    wait_tick(1, n);
    chk("stretched_period", 2 + 3 + n, 8);

    // sync aligns all channels, including a disabled one.
    set_ratio(0, 3); set_ratio(1, 7);
    en = 4'b0111;
    repeat ($urandom_range(5, 15)) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_tick", tick, 4'hF);
    chk("sync_clk_out", clk_out, 4'hF);

    // Asynchronous reset while channel 3 is high.
    en = 4'hF;
    set_ratio(3, 8);
    measure(3, 8, 4);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_clk_out", clk_out, 0);
    chk("async_reset_tick", tick, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_tick", tick, 4'hF);

    // Randomised run; the compare process checks every cycle.
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      en   = CH'($urandom);
      if ($urandom_range(0, 3) != 0) en = 4'hF;
      sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < CH; i++)
          set_ratio(i, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12));
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
